rw_request_scheduler: RTL and testbench

- Round-robin arbiter and sequencer that shares the single read/write transaction FSM between NUM_REQ host-side requesters.
- Latches the winning request and holds the FSM's read or write level for the whole transaction.
- Retries failed transactions up to MAX_RETRY times, then returns one completion pulse with status and read data to the requester.
- Sits between the host/OS request sources and the read/write FSM.

---
 rtl/rw_request_scheduler_pkg.sv | 11 +
 rtl/rw_request_scheduler_if.sv | 26 ++
 rtl/rw_request_scheduler_rr_arbiter.sv | 20 ++
 rtl/rw_request_scheduler.sv | 107 ++++++++++
 tb/tb_rw_request_scheduler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/rw_request_scheduler_pkg.sv
// rw_sched_pkg: shared widths, scheduler state enum and latched request struct
package rw_sched_pkg;
  localparam int PAGE_W = 16;
  localparam int DATA_W = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, RESP} sched_state_t;
  typedef struct packed {
    logic              write;
    logic [PAGE_W-1:0] page;
    logic [DATA_W-1:0] wdata;
  } rw_req_t;
endpackage

// File: rtl/rw_request_scheduler_if.sv
// rw_request_scheduler_if: requester bus (req_*/resp_*) and read/write FSM bus (rw_*) plus busy; slave = scheduler, master = environment
interface rw_request_scheduler_if import rw_sched_pkg::*; #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][PAGE_W-1:0] req_page;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_ack;
  logic                           resp_ok;
  logic [DATA_W-1:0]              resp_rdata;
  logic                           rw_read;
  logic                           rw_write;
  logic [PAGE_W-1:0]              rw_mempage;
  logic [DATA_W-1:0]              rw_wdata;
  logic                           rw_done;
  logic                           rw_ok;
  logic [DATA_W-1:0]              rw_rdata;
  logic                           busy;
  modport slave (
    input  req_valid, req_write, req_page, req_wdata, rw_done, rw_ok, rw_rdata,
    output req_ack, resp_ok, resp_rdata, rw_read, rw_write, rw_mempage, rw_wdata, busy
  );
  modport master (
    output req_valid, req_write, req_page, req_wdata, rw_done, rw_ok, rw_rdata,
    input  req_ack, resp_ok, resp_rdata, rw_read, rw_write, rw_mempage, rw_wdata, busy
  );
endinterface

// File: rtl/rw_request_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req_i bit at or above rr_ptr_i, wrapping; ports req_i, rr_ptr_i -> grant_valid_o, grant_idx_o
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      rr_ptr_i,
  output logic               grant_valid_o,
  output logic [IW-1:0]      grant_idx_o
);
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_i[(int'(rr_ptr_i) + k) % NUM_REQ]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = IW'((int'(rr_ptr_i) + k) % NUM_REQ);
      end
  end
endmodule

// File: rtl/rw_request_scheduler.sv
// rw_request_scheduler: round-robin sequencer sharing one read/write FSM among NUM_REQ requesters with retry; ports clk, rst, bus (slave modport), stat_ok/stat_fail/stat_retry when RW_SCHED_STATS_EN is defined
module rw_request_scheduler import rw_sched_pkg::*; #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_RETRY = 3
) (
  input logic clk,
  input logic rst,
  rw_request_scheduler_if.slave bus
`ifdef RW_SCHED_STATS_EN
  ,
  output logic [31:0] stat_ok,
  output logic [31:0] stat_fail,
  output logic [31:0] stat_retry
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  sched_state_t      state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, idx_q, idx_d, gnt_idx;
  logic [RW-1:0]     retry_q, retry_d;
  rw_req_t           req_q, req_d;
  logic              ok_q, ok_d, gnt_valid;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i(bus.req_valid),
    .rr_ptr_i(ptr_q),
    .grant_valid_o(gnt_valid),
    .grant_idx_o(gnt_idx)
  );
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    req_d   = req_q;
    ok_d    = ok_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (gnt_valid) begin
        idx_d   = gnt_idx;
        req_d   = '{write: bus.req_write[gnt_idx], page: bus.req_page[gnt_idx], wdata: bus.req_wdata[gnt_idx]};
        retry_d = '0;
        state_d = ISSUE;
      end
      ISSUE: if (bus.rw_done) begin
        if (bus.rw_ok) begin
          ok_d    = 1'b1;
          rdata_d = req_q.write ? '0 : bus.rw_rdata;
          state_d = RESP;
        end else if (int'(retry_q) < MAX_RETRY) begin
          retry_d = retry_q + RW'(1);
          state_d = GAP;
        end else begin
          ok_d    = 1'b0;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      GAP: state_d = ISSUE;
      default: begin
        ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      req_q   <= '0;
      ok_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      req_q   <= req_d;
      ok_q    <= ok_d;
      rdata_q <= rdata_d;
    end
  end
  // Levels gated by rw_done so the FSM sees them fall in its done cycle and cannot relaunch
  assign bus.rw_read    = (state_q == ISSUE) & ~req_q.write & ~bus.rw_done;
  assign bus.rw_write   = (state_q == ISSUE) & req_q.write & ~bus.rw_done;
  assign bus.rw_mempage = req_q.page;
  assign bus.rw_wdata   = req_q.wdata;
  assign bus.req_ack    = (state_q == RESP) ? NUM_REQ'(1) << idx_q : '0;
  assign bus.resp_ok    = ok_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.busy       = state_q != IDLE;
`ifdef RW_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ok    <= '0;
      stat_fail  <= '0;
      stat_retry <= '0;
    end else begin
      if (state_q == RESP && ok_q && ~&stat_ok) stat_ok <= stat_ok + 32'd1;
      if (state_q == RESP && !ok_q && ~&stat_fail) stat_fail <= stat_fail + 32'd1;
      if (state_q == ISSUE && state_d == GAP && ~&stat_retry) stat_retry <= stat_retry + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rw_request_scheduler.sv
// tb_rw_request_scheduler: directed self-checking bench with a small read/write FSM model
module tb_rw_request_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  rw_request_scheduler_if #(.NUM_REQ(2)) bus ();
`ifdef RW_SCHED_STATS_EN
  logic [31:0] stat_ok, stat_fail, stat_retry;
`endif
  rw_request_scheduler #(.NUM_REQ(2), .MAX_RETRY(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef RW_SCHED_STATS_EN
    ,
    .stat_ok(stat_ok),
    .stat_fail(stat_fail),
    .stat_retry(stat_retry)
`endif
  );
  // FSM model: launches on a level seen in its idle state, pulses done two cycles later,
  // and counts any level still high at the end of its done cycle as a relaunch
  int m_st = 0;
  int m_cnt = 0;
  int launches = 0;
  int relaunch = 0;
  bit ok_script[$];
  bit nx_ok;
  logic [63:0] m_rdata = '0;
  initial begin
    bus.rw_done = 1'b0;
    bus.rw_ok = 1'b0;
    bus.rw_rdata = '0;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_page = '0;
    bus.req_wdata = '0;
  end
  always @(posedge clk) begin
    if (rst) begin
      m_st <= 0;
      bus.rw_done <= 1'b0;
    end else if (m_st == 0) begin
      if (bus.rw_read || bus.rw_write) begin
        launches <= launches + 1;
        m_cnt <= 1;
        m_st <= 1;
      end
    end else if (m_st == 1) begin
      if (m_cnt == 0) begin
        nx_ok = (ok_script.size() > 0) ? ok_script.pop_front() : 1'b1;
        bus.rw_done <= 1'b1;
        bus.rw_ok <= nx_ok;
        bus.rw_rdata <= m_rdata;
        m_st <= 2;
      end else m_cnt <= m_cnt - 1;
    end else begin
      bus.rw_done <= 1'b0;
      if (bus.rw_read || bus.rw_write) begin
        relaunch <= relaunch + 1;
        launches <= launches + 1;
      end
      m_st <= 0;
    end
  end
  int gaps;
  int lvl_err;
  task automatic wait_ack(output logic [1:0] ack, output logic ok, output logic [63:0] rd, output bit to);
    to = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus.rw_done && (bus.rw_read || bus.rw_write)) lvl_err++;
      if (bus.busy && !bus.rw_read && !bus.rw_write && !bus.rw_done && bus.req_ack == 2'b00) gaps++;
      if (bus.req_ack != 2'b00) begin
        ack = bus.req_ack;
        ok = bus.resp_ok;
        rd = bus.resp_rdata;
        return;
      end
    end
    to = 1'b1;
    ack = '0;
    ok = 1'b0;
    rd = '0;
  endtask
  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    launches = 0;
    relaunch = 0;
    gaps = 0;
    lvl_err = 0;
    ok_script.delete();
  endtask
  task automatic test_reset();
    pulse_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.req_ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", bus.req_ack); end
    checks++; if ({bus.rw_read, bus.rw_write} !== 2'b00) begin errors++; $display("FAIL reset_levels: got %b want 00", {bus.rw_read, bus.rw_write}); end
    checks++; if (bus.resp_ok !== 1'b0) begin errors++; $display("FAIL reset_resp_ok: got %b want 0", bus.resp_ok); end
    checks++; if (bus.resp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata); end
    checks++; if (bus.rw_mempage !== 16'd0) begin errors++; $display("FAIL reset_page: got %h want 0", bus.rw_mempage); end
  endtask
  task automatic test_single_read();
    logic [1:0] ack; logic ok; logic [63:0] rd; bit to;
    pulse_reset();
    bus.req_page[0] = 16'h0042;
    bus.req_write = 2'b00;
    m_rdata = 64'hDEADBEEF_00000001;
    bus.req_valid = 2'b01;
    @(posedge clk); #1;
    checks++; if ({bus.busy, bus.rw_read, bus.rw_write} !== 3'b110) begin errors++; $display("FAIL read_grant: got busy/rd/wr %b want 110", {bus.busy, bus.rw_read, bus.rw_write}); end
    checks++; if (bus.rw_mempage !== 16'h0042) begin errors++; $display("FAIL read_page: got %h want 0042", bus.rw_mempage); end
    bus.req_page[0] = 16'hFFFF;
    @(posedge clk); #1;
    checks++; if (bus.rw_mempage !== 16'h0042) begin errors++; $display("FAIL read_page_held: got %h want 0042", bus.rw_mempage); end
    wait_ack(ack, ok, rd, to);
    bus.req_valid = 2'b00;
    checks++; if (to) begin errors++; $display("FAIL read_timeout: got no ack want ack"); end
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL read_ack: got %b want 01", ack); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL read_ok: got %b want 1", ok); end
    checks++; if (rd !== 64'hDEADBEEF_00000001) begin errors++; $display("FAIL read_rdata: got %h want deadbeef00000001", rd); end
    checks++; if (launches !== 1 || relaunch !== 0 || lvl_err !== 0) begin errors++; $display("FAIL read_launch: got launches=%0d relaunch=%0d lvl=%0d want 1 0 0", launches, relaunch, lvl_err); end
    @(posedge clk); #1;
    checks++; if ({bus.req_ack, bus.busy} !== 3'b000) begin errors++; $display("FAIL read_ack_pulse: got ack/busy %b want 000", {bus.req_ack, bus.busy}); end
  endtask
  task automatic test_contention();
    logic [1:0] ack; logic ok; logic [63:0] rd; bit to;
    logic [1:0] exp_ack [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] exp_pg [4] = '{16'h0100, 16'h0200, 16'h0100, 16'h0200};
    pulse_reset();
    bus.req_page[0] = 16'h0100;
    bus.req_page[1] = 16'h0200;
    bus.req_write = 2'b00;
    bus.req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_ack(ack, ok, rd, to);
      if (n == 3) bus.req_valid = 2'b00;
      checks++; if (to || ack !== exp_ack[n]) begin errors++; $display("FAIL rr_ack%0d: got %b want %b", n, ack, exp_ack[n]); end
      checks++; if (bus.rw_mempage !== exp_pg[n]) begin errors++; $display("FAIL rr_page%0d: got %h want %h", n, bus.rw_mempage, exp_pg[n]); end
    end
  endtask
  task automatic test_retry_success();
    logic [1:0] ack; logic ok; logic [63:0] rd; bit to;
    pulse_reset();
    ok_script = '{1'b0, 1'b0, 1'b1};
    m_rdata = 64'h5555_AAAA_5555_AAAA;
    bus.req_write = 2'b01;
    bus.req_wdata[0] = 64'h0123_4567_89AB_CDEF;
    bus.req_valid = 2'b01;
    @(posedge clk); #1;
    checks++; if ({bus.rw_read, bus.rw_write} !== 2'b01 || bus.rw_wdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL retry_issue: got rd/wr %b wdata %h want 01 0123456789abcdef", {bus.rw_read, bus.rw_write}, bus.rw_wdata); end
    wait_ack(ack, ok, rd, to);
    bus.req_valid = 2'b00;
    checks++; if (to || ack !== 2'b01) begin errors++; $display("FAIL retry_ack: got %b want 01", ack); end
    checks++; if (ok !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL retry_resp: got ok=%b rdata=%h want 1 0", ok, rd); end
    checks++; if (launches !== 3) begin errors++; $display("FAIL retry_windows: got %0d want 3", launches); end
    checks++; if (gaps !== 2) begin errors++; $display("FAIL retry_gaps: got %0d want 2", gaps); end
    checks++; if (relaunch !== 0 || lvl_err !== 0) begin errors++; $display("FAIL retry_relaunch: got %0d/%0d want 0/0", relaunch, lvl_err); end
  endtask
  task automatic test_retry_exhaust();
    logic [1:0] ack; logic ok; logic [63:0] rd; bit to;
    pulse_reset();
    ok_script = '{1'b0, 1'b0, 1'b0, 1'b0};
    m_rdata = 64'hFFFF_0000_FFFF_0000;
    bus.req_write = 2'b00;
    bus.req_valid = 2'b01;
    wait_ack(ack, ok, rd, to);
    bus.req_valid = 2'b00;
    checks++; if (to || ack !== 2'b01) begin errors++; $display("FAIL exhaust_ack: got %b want 01", ack); end
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL exhaust_ok: got %b want 0", ok); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL exhaust_rdata: got %h want 0", rd); end
    checks++; if (launches !== 4) begin errors++; $display("FAIL exhaust_windows: got %0d want 4", launches); end
    checks++; if (gaps !== 3) begin errors++; $display("FAIL exhaust_gaps: got %0d want 3", gaps); end
    checks++; if (relaunch !== 0 || lvl_err !== 0) begin errors++; $display("FAIL exhaust_relaunch: got %0d/%0d want 0/0", relaunch, lvl_err); end
  endtask
  task automatic test_reset_mid_issue();
    logic [1:0] ack; logic ok; logic [63:0] rd; bit to;
    pulse_reset();
    bus.req_write = 2'b00;
    bus.req_valid = 2'b01;
    wait_ack(ack, ok, rd, to);
    checks++; if (to || ack !== 2'b01) begin errors++; $display("FAIL mid_first_ack: got %b want 01", ack); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.rw_read !== 1'b1) begin errors++; $display("FAIL mid_in_issue: got rw_read=%b want 1", bus.rw_read); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({bus.busy, bus.rw_read, bus.rw_write, bus.req_ack} !== 5'b00000) begin errors++; $display("FAIL mid_reset_state: got busy/rd/wr/ack %b want 00000", {bus.busy, bus.rw_read, bus.rw_write, bus.req_ack}); end
    bus.req_valid = 2'b11;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b1 || bus.rw_read !== 1'b1) begin errors++; $display("FAIL mid_regrant: got busy=%b rd=%b want 1 1", bus.busy, bus.rw_read); end
    wait_ack(ack, ok, rd, to);
    bus.req_valid = 2'b00;
    checks++; if (to || ack !== 2'b01) begin errors++; $display("FAIL mid_ptr_cleared: got %b want 01", ack); end
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_retry_success();
    test_retry_exhaust();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
